// File: rtl/divide_mode_ctrl_if.sv
// Button, load and mode-word signals between the mode selector and its host.
// The divider side only consumes control/mode_chg.
interface divide_mode_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       load;
  logic [1:0] load_mode;
  logic [1:0] control;
  logic       mode_chg;

  modport slave (
    input  btn_up,
    input  btn_down,
    input  load,
    input  load_mode,
    output control,
    output mode_chg
  );

  modport master (
    output btn_up,
    output btn_down,
    output load,
    output load_mode,
    input  control,
    input  mode_chg
  );
endinterface

// File: rtl/divide_mode_ctrl.sv
// Divide-mode selector: synchronizes and debounces up/down buttons, steps a wrapping
// 2-bit mode word on each press, and accepts a direct load that overrides button events.
module divide_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic               clk,
  input  logic               reset,
  divide_mode_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is the up button, bit 1 the down button.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       db_q, db_d;
  logic [1:0]       db_prev_q, db_prev_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       press;
  logic [1:0]       control_q, control_d;
  logic             mode_chg_q, mode_chg_d;

  assign btn_raw = {bus.btn_down, bus.btn_up};

  // Synchronizer and debounce next state.
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    db_d      = db_q;
    db_prev_d = db_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Rising edge of the debounced level only; releases are ignored.
  assign press = db_q & ~db_prev_q;

  // Mode word update: load beats any button event, and an up/down tie cancels out.
  always_comb begin
    control_d = control_q;
    if (bus.load) begin
      control_d = bus.load_mode;
    end else begin
      unique case (press)
        2'b01:   control_d = control_q + 2'd1;
        2'b10:   control_d = control_q - 2'd1;
        default: control_d = control_q;
      endcase
    end
    mode_chg_d = (control_d != control_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      db_prev_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
      control_q  <= '0;
      mode_chg_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      db_prev_q  <= db_prev_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      control_q  <= control_d;
      mode_chg_q <= mode_chg_d;
    end
  end

  assign bus.control  = control_q;
  assign bus.mode_chg = mode_chg_q;

endmodule
